cnn_mac_pipe: RTL and testbench

CNN_MAC_PIPE -- requirements
Module: cnn_mac_pipe

---
 rtl/cnn_mac_pkg.sv | 32 +++
 rtl/cnn_mac_pipe_mul.sv | 76 +++++++
 rtl/cnn_mac_pipe.sv | 111 +++++++++++
 tb/tb_cnn_mac_pipe.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_mac_pkg.sv
// Shared defaults and rounding/saturation helpers for the CNN MAC pipe.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package cnn_mac_pkg;

  localparam int DEF_DIN0_WIDTH = 14;
  localparam int DEF_DIN1_WIDTH = 9;
  localparam int DEF_ACC_WIDTH  = 24;
  localparam int DEF_DOUT_WIDTH = 16;
  localparam int DEF_NUM_STAGE  = 3;
  localparam int DEF_FRAC_SHIFT = 4;

  // Wide signed carrier; accumulators up to 62 bits sign-extend into it
  // without the rounding add ever overflowing.
  typedef logic signed [63:0] wide_t;

  // Round half up, then arithmetic shift right.
  function automatic wide_t round_shift(input wide_t v, input int shift);
    return (v + (64'sd1 <<< (shift - 1))) >>> shift;
  endfunction

  // Largest value representable in a signed field of the given width.
  function automatic wide_t sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a signed field of the given width.
  function automatic wide_t sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/cnn_mac_pipe_mul.sv
// Signed full-precision multiplier, NUM_STAGE registers deep, with tag passthrough.
// Latency: NUM_STAGE ce-enabled edges from operand to product.
// Backpressure: none; ce=0 freezes every stage in place.
module cnn_mac_pipe_mul
  import cnn_mac_pkg::*;
#(
  parameter int A_WIDTH   = DEF_DIN0_WIDTH,
  parameter int B_WIDTH   = DEF_DIN1_WIDTH,
  parameter int NUM_STAGE = DEF_NUM_STAGE
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ce,
  input  logic                              in_vld,
  input  logic                              in_first,
  input  logic                              in_last,
  input  logic signed [A_WIDTH-1:0]         a,
  input  logic signed [B_WIDTH-1:0]         b,
  output logic                              out_vld,
  output logic                              out_first,
  output logic                              out_last,
  output logic signed [A_WIDTH+B_WIDTH-1:0] p
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  logic [NUM_STAGE-1:0]       vld_q, vld_d;
  logic [NUM_STAGE-1:0]       first_q, first_d;
  logic [NUM_STAGE-1:0]       last_q, last_d;
  logic signed [P_WIDTH-1:0]  prod_q [NUM_STAGE];
  logic signed [P_WIDTH-1:0]  prod_d [NUM_STAGE];

  // Shift products and tags one stage per enabled edge; tags are gated by valid.
  always_comb begin
    vld_d   = vld_q;
    first_d = first_q;
    last_d  = last_q;
    prod_d  = prod_q;
    if (ce) begin
      vld_d[0]   = in_vld;
      first_d[0] = in_vld & in_first;
      last_d[0]  = in_vld & in_last;
      prod_d[0]  = P_WIDTH'(a) * P_WIDTH'(b);
      for (int s = 1; s < NUM_STAGE; s++) begin
        vld_d[s]   = vld_q[s-1];
        first_d[s] = first_q[s-1];
        last_d[s]  = last_q[s-1];
        prod_d[s]  = prod_q[s-1];
      end
    end
  end

  // Tag registers carry the control meaning, so they are the ones reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      vld_q   <= vld_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  // Product registers stay reset-free so they can fold into the DSP pipeline.
  always_ff @(posedge clk) begin
    prod_q <= prod_d;
  end

  assign out_vld   = vld_q[NUM_STAGE-1];
  assign out_first = first_q[NUM_STAGE-1];
  assign out_last  = last_q[NUM_STAGE-1];
  assign p         = prod_q[NUM_STAGE-1];

endmodule

// File: rtl/cnn_mac_pipe.sv
// Windowed signed MAC: pipelined multiply, accumulate, round, saturate per window.
// Latency: out_valid NUM_STAGE+1 enabled edges after the last term is accepted.
// Backpressure: none; ce=0 holds the whole pipe including a pending out_valid.
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = DEF_DIN0_WIDTH,
  parameter int DIN1_WIDTH = DEF_DIN1_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
  parameter int NUM_STAGE  = DEF_NUM_STAGE,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  output logic                         out_valid,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         sat
);

  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

  logic                         mul_vld;
  logic                         mul_first;
  logic                         mul_last;
  logic signed [PROD_WIDTH-1:0] mul_p;

  cnn_mac_pipe_mul #(
    .A_WIDTH   (DIN0_WIDTH),
    .B_WIDTH   (DIN1_WIDTH),
    .NUM_STAGE (NUM_STAGE)
  ) u_mul (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .ce        (ce),
    .in_vld    (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .a         (din0),
    .b         (din1),
    .out_vld   (mul_vld),
    .out_first (mul_first),
    .out_last  (mul_last),
    .p         (mul_p)
  );

  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic                         sat_q, sat_d;
  logic                         out_valid_q, out_valid_d;
  wide_t                        rnd;

  // Accumulate each product; on the last term round and clip the freshly updated sum.
  always_comb begin
    acc_d       = acc_q;
    dout_d      = dout_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    rnd         = '0;
    if (ce) begin
      out_valid_d = 1'b0;
      if (mul_vld) begin
        if (mul_first) begin
          acc_d = ACC_WIDTH'(mul_p);
        end else begin
          acc_d = acc_q + ACC_WIDTH'(mul_p);
        end
        if (mul_last) begin
          rnd         = round_shift(wide_t'(acc_d), FRAC_SHIFT);
          out_valid_d = 1'b1;
          if (rnd > sat_max(DOUT_WIDTH)) begin
            dout_d = DOUT_WIDTH'(sat_max(DOUT_WIDTH));
            sat_d  = 1'b1;
          end else if (rnd < sat_min(DOUT_WIDTH)) begin
            dout_d = DOUT_WIDTH'(sat_min(DOUT_WIDTH));
            sat_d  = 1'b1;
          end else begin
            dout_d = DOUT_WIDTH'(rnd);
            sat_d  = 1'b0;
          end
        end
      end
    end
  end

  // Result and accumulator state; reset discards any window in flight.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc_q       <= '0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      dout_q      <= dout_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Self-checking bench for cnn_mac_pipe with default parameters.
// Results are predicted at drive time and matched against each new out_valid pulse.
// Covers saturation, rounding, back-to-back windows, ce stalls and reset mid-window.
module tb_cnn_mac_pipe;

  localparam int NS = 3;

  logic                ap_clk = 1'b0;
  logic                ap_rst_n;
  logic                ce;
  logic                in_valid;
  logic                in_first;
  logic                in_last;
  logic signed [13:0]  din0;
  logic signed [8:0]   din1;
  logic                out_valid;
  logic signed [15:0]  dout;
  logic                sat;

  cnn_mac_pipe dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .dout      (dout),
    .sat       (sat)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    bit first;
    bit last;
    int d0;
    int d1;
    int exp_dout;
    bit exp_sat;
  } vec_t;

  typedef struct {
    int dout;
    bit sat;
    int cyc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   cyc     = 0;
  bit   ce_edge = 1'b0;
  int   n_chk   = 0;
  int   n_pass  = 0;

  always @(posedge ap_clk) begin
    cyc     <= cyc + 1;
    ce_edge <= ce;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // A pulse is new only if the preceding edge was enabled; a stalled strobe is the same result.
  always @(negedge ap_clk) begin : mon
    exp_t e;
    if (out_valid === 1'b1 && ce_edge) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_out_valid: got pulse at cycle %0d, required none", cyc);
      end else begin
        e = sb.pop_front();
        check("dout", dout, e.dout);
        check("sat", sat, e.sat);
        check("latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive(input bit f, input bit l, input int d0, input int d1,
                       input bit push, input int ed, input bit es);
    exp_t e;
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    din0     = 14'(d0);
    din1     = 9'(d1);
    if (push) begin
      e.dout = ed;
      e.sat  = es;
      e.cyc  = cyc + 1 + NS;
      sb.push_back(e);
    end
    tick();
  endtask

  // Idle cycle with garbage on the tag and data lines, which must be ignored.
  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'($urandom);
    in_last  = 1'($urandom);
    din0     = 14'($urandom);
    din1     = 9'($urandom);
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) idle();
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic void model(input logic signed [23:0] acc, output int d, output bit s);
    longint r;
    r = (longint'(acc) + 8) >>> 4;
    if (r > 32767) begin
      d = 32767;  s = 1'b1;
    end else if (r < -32768) begin
      d = -32768; s = 1'b1;
    end else begin
      d = int'(r); s = 1'b0;
    end
  endfunction

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    exp_t                 e;
    logic signed [23:0]   macc;
    int                   len, d0, d1, ed, p0;
    bit                   es;

    tbl.push_back('{1, 1, -8192, -256, 32767, 1});
    tbl.push_back('{1, 0, 100, 10, 0, 0});
    tbl.push_back('{0, 0, -50, 20, 0, 0});
    tbl.push_back('{0, 0, 3, -7, 0, 0});
    tbl.push_back('{0, 1, 1000, 1, 61, 0});
    tbl.push_back('{1, 1, -3, 8, -1, 0});
    tbl.push_back('{1, 1, 2, 3, 0, 0});
    tbl.push_back('{1, 0, 4, 5, 0, 0});
    tbl.push_back('{0, 1, 6, 7, 4, 0});
    tbl.push_back('{1, 1, -8192, 255, -32768, 1});
    tbl.push_back('{1, 1, 1, 8, 1, 0});
    tbl.push_back('{1, 1, -1, 8, 0, 0});
    tbl.push_back('{1, 1, -1, 9, -1, 0});
    tbl.push_back('{1, 1, 3472, 151, 32767, 0});
    tbl.push_back('{1, 1, 2056, 255, 32767, 1});

    ap_rst_n = 1'b0;
    ce       = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    din0     = '0;
    din1     = '0;
    tick(); tick(); tick();
    check("reset_out_valid", out_valid, 0);
    check("reset_dout", dout, 0);
    check("reset_sat", sat, 0);
    ap_rst_n = 1'b1;
    ce       = 1'b1;
    idle();

    // Directed vectors, applied on consecutive edges (back-to-back windows).
    for (int i = 0; i < tbl.size(); i++)
      drive(tbl[i].first, tbl[i].last, tbl[i].d0, tbl[i].d1,
            tbl[i].last, tbl[i].exp_dout, tbl[i].exp_sat);
    drain();

    // Random windows of 1..4 terms, predicted by a bench-side accumulator.
    macc = '0;
    for (int w = 0; w < 15; w++) begin
      len = int'($urandom_range(1, 4));
      for (int t = 0; t < len; t++) begin
        d0 = int'($urandom_range(0, 16383)) - 8192;
        d1 = int'($urandom_range(0, 511)) - 256;
        macc = (t == 0) ? 24'(d0 * d1) : macc + 24'(d0 * d1);
        model(macc, ed, es);
        drive(t == 0, t == len - 1, d0, d1, t == len - 1, ed, es);
      end
    end
    drain();

    // ce stall of 5 cycles mid-window while inputs keep toggling.
    p0    = cyc;
    e.dout = 61;
    e.sat  = 1'b0;
    e.cyc  = p0 + 4 + NS + 5;
    sb.push_back(e);
    drive(1, 0, 100, 10, 0, 0, 0);
    drive(0, 0, -50, 20, 0, 0, 0);
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_first = 1'($urandom);
      in_last  = 1'($urandom);
      din0     = 14'($urandom);
      din1     = 9'($urandom);
      tick();
    end
    ce = 1'b1;
    drive(0, 0, 3, -7, 0, 0, 0);
    drive(0, 1, 1000, 1, 0, 0, 0);
    drain();

    // A pending strobe is held through a stall and clears on the next enabled edge.
    drive(1, 1, -3, 8, 1, -1, 0);
    idle(); idle(); idle();
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_first = 1'b1;
      in_last  = 1'b1;
      din0     = 14'($urandom);
      din1     = 9'($urandom);
      tick();
      @(negedge ap_clk);
      check("stall_out_valid_held", out_valid, 1);
      check("stall_dout_held", dout, -1);
    end
    ce = 1'b1;
    idle();
    @(negedge ap_clk);
    check("post_stall_out_valid", out_valid, 0);
    check("post_stall_dout_stable", dout, -1);
    check("post_stall_sat_stable", sat, 0);
    drain();

    // Reset with a complete two-term window still inside the multiplier.
    drive(1, 0, 100, 10, 0, 0, 0);
    drive(0, 1, -50, 20, 0, 0, 0);
    in_valid = 1'b0;
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_dout", dout, 0);
    check("midreset_sat", sat, 0);
    for (int i = 0; i < 8; i++) idle();
    drive(1, 0, 100, 10, 0, 0, 0);
    drive(0, 0, -50, 20, 0, 0, 0);
    drive(0, 0, 3, -7, 0, 0, 0);
    drive(0, 1, 1000, 1, 1, 61, 0);
    drain();
    for (int i = 0; i < 6; i++) idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
